// File: rtl/mips_pkg.sv
// Shared MIPS constants for the fetch/execute slice.
//   - ALUOp encodings driven by the main control unit
//   - 4-bit ALU control codes consumed by alu_core
//   - R-type opcode and funct field encodings
package mips_pkg;

    // ALUOp from main control
    localparam logic [1:0] ALUOP_MEM = 2'b00;  // lw/sw address add
    localparam logic [1:0] ALUOP_BR  = 2'b01;  // beq compare via sub
    localparam logic [1:0] ALUOP_R   = 2'b10;  // R-type, decode funct

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    // Opcode / funct
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

endpackage

// File: rtl/imem_alu_exec_alu_core.sv
// Purely combinational 32-bit ALU.
//   ctrl : 4-bit ALU control code (mips_pkg ALU_*)
//   a, b : operands
//   y    : result; unknown codes (including ALU_NOP) give 0
module alu_core
    import mips_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = 32'd0;
        case (ctrl)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;     // wraps, no overflow detection
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            ALU_NOR: y = ~(a | b);
            default: y = 32'd0;
        endcase
    end

endmodule

// File: rtl/imem_alu_exec.sv
// Fetch-and-execute slice: instruction ROM with registered read, ALU
// control decode, and a registered ALU result.
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   pc_addr     : byte address; bits [1:0] and bits above the ROM index ignored
//   alu_op      : ALUOp from main control
//   operand_a/b : ALU operands
//   instruction : fetched word, one cycle after pc_addr
//   alu_ctrl    : combinational decode of alu_op + instruction funct
//   alu_result  : registered ALU output
//   zero        : alu_result == 0
module imem_alu_exec
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    // ROM image is the built-in program; the name is carried so the
    // block drops in where a file-loaded image is configured.
    parameter     MEM_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    input  logic [1:0]  alu_op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] instruction,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic        zero
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [AW-1:0] rom_idx;
    logic [31:0]   alu_y;
    logic          unused_addr;

    // Only word index bits select the ROM word; the rest wrap away.
    assign rom_idx     = pc_addr[AW+1:2];
    assign unused_addr = ^{pc_addr[31:AW+2], pc_addr[1:0]};

    // Default program; every other word reads as 0.
    function automatic logic [31:0] rom_word(input logic [AW-1:0] idx);
        case (int'(idx))
            0:       return 32'h0022_1820;  // add $3,$1,$2
            1:       return 32'h0022_2022;  // sub $4,$1,$2
            2:       return 32'h0022_2824;  // and $5,$1,$2
            3:       return 32'h0022_3025;  // or  $6,$1,$2
            4:       return 32'h0022_3827;  // nor $7,$1,$2
            5:       return 32'h0022_402A;  // slt $8,$1,$2
            default: return 32'h0000_0000;
        endcase
    endfunction

    always_comb begin
        alu_ctrl = ALU_NOP;
        case (alu_op)
            ALUOP_MEM: alu_ctrl = ALU_ADD;
            ALUOP_BR:  alu_ctrl = ALU_SUB;
            ALUOP_R: begin
                case (instruction[5:0])
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_NOP;
                endcase
            end
            default:   alu_ctrl = ALU_NOP;
        endcase
    end

    alu_core u_alu (
        .ctrl (alu_ctrl),
        .a    (operand_a),
        .b    (operand_b),
        .y    (alu_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= 32'd0;
            alu_result  <= 32'd0;
        end else begin
            instruction <= rom_word(rom_idx);
            alu_result  <= alu_y;
        end
    end

    assign zero = (alu_result == 32'd0);

endmodule

// File: tb/tb_imem_alu_exec.sv
module tb_imem_alu_exec;

    logic        clk;
    logic        reset;
    logic [31:0] pc_addr;
    logic [1:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] instruction;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    imem_alu_exec #(.MEM_WORDS(64), .MEM_FILE("")) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .alu_op      (alu_op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .instruction (instruction),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sweep_exp [6];

    initial begin
        sweep_exp[0] = 32'h0000_0016;
        sweep_exp[1] = 32'h0000_0002;
        sweep_exp[2] = 32'h0000_0008;
        sweep_exp[3] = 32'h0000_000E;
        sweep_exp[4] = 32'hFFFF_FFF1;
        sweep_exp[5] = 32'h0000_0000;

        reset     = 1'b1;
        pc_addr   = 32'd0;
        alu_op    = 2'b10;
        operand_a = 32'h0000_000C;
        operand_b = 32'h0000_000A;

        // 1. reset
        #2 reset = 1'b0;
        #1;
        check("rst_instr",  instruction, 32'd0);
        check("rst_result", alu_result,  32'd0);
        check("rst_zero",   {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("first_fetch", instruction, 32'h0022_1820);
        check("first_ctrl",  {28'd0, alu_ctrl}, 32'h2);

        // 2. sweep: result of word k shows one edge after its fetch
        for (int k = 1; k <= 6; k++) begin
            pc_addr = 32'(k * 4);
            step();
            check($sformatf("sweep_res%0d", k - 1), alu_result, sweep_exp[k - 1]);
        end
        check("sweep_zero", {31'd0, zero}, 32'd1);

        // 3. slt signedness
        pc_addr = 32'd20;
        step();
        check("slt_fetch", instruction, 32'h0022_402A);
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'd1;
        step();
        check("slt_neg", alu_result, 32'd1);
        operand_a = 32'd1;
        operand_b = 32'hFFFF_FFFF;
        step();
        check("slt_swap", alu_result, 32'd0);
        check("slt_swap_zero", {31'd0, zero}, 32'd1);

        // 4. alu_op overrides
        alu_op    = 2'b00;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'd1;
        #1;
        check("op00_ctrl", {28'd0, alu_ctrl}, 32'h2);
        step();
        check("op00_wrap", alu_result, 32'd0);
        check("op00_zero", {31'd0, zero}, 32'd1);

        alu_op    = 2'b01;
        operand_a = 32'd5;
        operand_b = 32'd5;
        #1;
        check("op01_ctrl", {28'd0, alu_ctrl}, 32'h6);
        step();
        check("op01_zero", {31'd0, zero}, 32'd1);

        alu_op    = 2'b00;
        operand_a = 32'd1;
        operand_b = 32'd1;
        step();
        check("op00_add", alu_result, 32'd2);
        alu_op    = 2'b11;
        operand_a = 32'h0000_000C;
        operand_b = 32'h0000_000A;
        #1;
        check("op11_ctrl", {28'd0, alu_ctrl}, 32'hF);
        step();
        check("op11_res", alu_result, 32'd0);

        // unknown funct: word 6 is 0, funct 000000
        alu_op  = 2'b00;
        pc_addr = 32'd24;
        step();
        check("unk_pre", alu_result, 32'h16);
        check("unk_fetch", instruction, 32'd0);
        alu_op = 2'b10;
        #1;
        check("unk_ctrl", {28'd0, alu_ctrl}, 32'hF);
        step();
        check("unk_res", alu_result, 32'd0);

        // 5. wrap and misalignment
        pc_addr = 32'h0000_0100;
        step();
        check("wrap_fetch", instruction, 32'h0022_1820);
        pc_addr = 32'h0000_0007;
        step();
        check("misalign_fetch", instruction, 32'h0022_2022);

        // 6. async reset mid-cycle
        pc_addr = 32'd0;
        step();
        step();
        check("pre_rst_res", alu_result, 32'h16);
        #2 reset = 1'b0;
        #1;
        check("async_res",   alu_result,  32'd0);
        check("async_instr", instruction, 32'd0);
        check("async_zero",  {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("post_rst_fetch", instruction, 32'h0022_1820);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
